fir_mac_sequencer: RTL and testbench

Time-multiplexed scheduler for the FIR datapath. One shared multiply-accumulate unit serves all N_TAPS taps, so the filter fits the tile's area budget. The block keeps the sample history in a circular buffer and steps the tap index and coefficient address once per tap. It presents one saturated output sample per accepted input, using valid/ready handshakes on both sides. It sits between the pin-level input register and the y_out pins inside the top-level wrapper; coefficients come from an external combinational coefficient ROM.

---
 rtl/fir_mac_sequencer.sv | 86 ++++++++
 tb/tb_fir_mac_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR scheduler sharing one MAC across all taps
module fir_mac_sequencer #(
  parameter int N_TAPS = 10,
  parameter int BW_in = 6,
  parameter int BW_coef = 6,
  parameter int BW_out = 6,
  parameter int SHIFT = 0,
  localparam int BW_addr = $clog2(N_TAPS),
  localparam int BW_acc = BW_in + BW_coef + $clog2(N_TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [BW_in-1:0]   x_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BW_addr-1:0] coef_addr,
  input  logic [BW_coef-1:0] coef_data,
  output logic [BW_out-1:0]  y_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);
  localparam logic [1:0] IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2;
  localparam logic [BW_addr-1:0] last = BW_addr'(N_TAPS - 1);
  localparam logic signed [BW_acc-1:0] y_max = BW_acc'((1 << (BW_out - 1)) - 1);
  localparam logic signed [BW_acc-1:0] y_min = BW_acc'(-(1 << (BW_out - 1)));
  logic [1:0] state;
  logic [BW_in-1:0] hist [N_TAPS];
  logic [BW_addr-1:0] wr_ptr, rd_ptr, tap;
  logic [BW_in-1:0] xr;
  logic signed [BW_acc-1:0] acc, xe, ce, sh;
  logic [BW_out-1:0] sat;
  assign xr = hist[rd_ptr];
  assign xe = {{(BW_acc - BW_in){xr[BW_in-1]}}, xr};
  assign ce = {{(BW_acc - BW_coef){coef_data[BW_coef-1]}}, coef_data};
  assign sh = acc >>> SHIFT;
  assign sat = sh > y_max ? y_max[BW_out-1:0] : sh < y_min ? y_min[BW_out-1:0] : sh[BW_out-1:0];
  assign in_ready = state == IDLE && !clear && !rst;
  assign busy = state != IDLE;
  assign coef_addr = tap;
  // rd_ptr walks backwards from the newest sample so tap k meets x[n-k]
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tap <= '0;
      acc <= '0;
      y_out <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) hist[i] <= '0;
    end else begin
      case (state)
        IDLE:
          if (clear) begin
            for (int i = 0; i < N_TAPS; i++) hist[i] <= '0;
            wr_ptr <= '0;
          end else if (in_valid) begin
            hist[wr_ptr] <= x_in;
            rd_ptr <= wr_ptr;
            tap <= '0;
            acc <= '0;
            state <= MAC;
          end
        MAC: begin
          acc <= acc + xe * ce;
          rd_ptr <= rd_ptr == '0 ? last : rd_ptr - 1'b1;
          if (tap == last) begin
            state <= OUT;
            wr_ptr <= wr_ptr == last ? '0 : wr_ptr + 1'b1;
          end else tap <= tap + 1'b1;
        end
        OUT:
          if (!out_valid) begin
            y_out <= sat;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed and randomized checks against a convolution reference model
module tb_fir_mac_sequencer;
  localparam int N = 10;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 1;
  logic [5:0] x_in = '0;
  logic [3:0] coef_addr;
  logic [5:0] coef_data, y_out;
  logic in_ready, out_valid, busy;
  logic signed [5:0] coef [N];
  int xh [N];
  int checks = 0, errors = 0;
  int y;

  always #5 clk = ~clk;
  assign coef_data = coef_addr < N ? coef[coef_addr] : '0;

  fir_mac_sequencer dut (
    .clk(clk), .rst(rst), .clear(clear), .x_in(x_in), .in_valid(in_valid),
    .in_ready(in_ready), .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_y();
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(coef[k]) * xh[k];
    s = s >>> 0;
    return s > 31 ? 31 : s < -32 ? -32 : s;
  endfunction

  task automatic push(input int x);
    for (int k = N - 1; k > 0; k--) xh[k] = xh[k-1];
    xh[0] = x;
  endtask

  task automatic zero_hist();
    for (int k = 0; k < N; k++) xh[k] = 0;
  endtask

  task automatic set_coef(input int v);
    for (int k = 0; k < N; k++) coef[k] = 6'(v);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    zero_hist();
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
    zero_hist();
  endtask

  task automatic send(input int x, input int hold, output int yo);
    int n = 0, lat = 0;
    while (!in_ready && n < 30) begin @(negedge clk); n++; end
    check("ready_timeout", int'(n < 30), 1);
    x_in = 6'(x);
    in_valid = 1;
    if (hold > 0) out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    push(x);
    check("mac_busy", int'(busy), 1);
    check("mac_addr0", int'(coef_addr), 0);
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("latency", lat, N + 1);
    yo = int'($signed(y_out));
    check("y_model", yo, model_y());
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      x_in = 6'($urandom);
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_y", int'($signed(y_out)), yo);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("handshake_valid", int'(out_valid), 0);
    check("idle_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_hist();
    set_coef(1);
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_addr", int'(coef_addr), 0);
    check("rst_busy", int'(busy), 0);
    rst = 0;
    #1;
    check("post_rst_ready", int'(in_ready), 1);

    // impulse with unit coefficients
    send(5, 0, y);
    check("impulse_0", y, 5);
    for (int i = 1; i <= N; i++) begin
      send(0, 0, y);
      check("impulse_tail", y, i < N ? 5 : 0);
    end

    // ramp coefficients on fresh history
    do_reset();
    for (int k = 0; k < N; k++) coef[k] = 6'(k);
    send(1, 0, y); check("ramp_0", y, 0);
    send(2, 0, y); check("ramp_1", y, 1);
    send(3, 0, y); check("ramp_2", y, 4);

    // saturation both ways
    set_coef(31);
    for (int i = 0; i < N; i++) send(31, 0, y);
    check("sat_pos", y, 31);
    do_clear();
    send(-32, 0, y);
    check("sat_neg", y, -32);

    // backpressure with ignored in_valid pulses
    set_coef(1);
    send(4, 5, y);
    send(1, 0, y);
    check("bp_follow", y, 1 + 4 - 32);

    // clear wins over in_valid
    send(3, 0, y); send(4, 0, y); send(5, 0, y);
    clear = 1; in_valid = 1; x_in = 6'd9;
    #1;
    check("clear_ready", int'(in_ready), 0);
    @(negedge clk);
    clear = 0; in_valid = 0;
    check("clear_no_accept", int'(busy), 0);
    zero_hist();
    send(7, 0, y);
    check("clear_result", y, 7);

    // reset in the middle of MAC
    for (int k = 0; k < N; k++) coef[k] = 6'($urandom);
    x_in = 6'd20; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("midmac_ready", int'(in_ready), 1);
    check("midmac_busy", int'(busy), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin @(negedge clk); seen += int'(out_valid); end
      check("midmac_no_output", seen, 0);
    end
    zero_hist();
    send(3, 0, y);
    check("midmac_impulse", y, model_y());

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) for (int k = 0; k < N; k++) coef[k] = 6'($urandom);
      if ($urandom_range(0, 9) == 0) do_clear();
      send(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 3)), y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
